// File: rtl/lsu_bus_if.sv
// Load/store unit: turns one core memory access into a single word-aligned req/ack
// bus transaction, stalls the core meanwhile and returns extended load data.
module lsu_bus_if #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  data_mem_mode,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        misaligned,
   output logic        bus_err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   output logic [1:0]  dbg_state
);

   localparam logic [2:0] DM_LB  = 3'd0;
   localparam logic [2:0] DM_LH  = 3'd1;
   localparam logic [2:0] DM_LW  = 3'd2;
   localparam logic [2:0] DM_LBU = 3'd3;
   localparam logic [2:0] DM_LHU = 3'd4;
   localparam logic [2:0] DM_SB  = 3'd5;
   localparam logic [2:0] DM_SH  = 3'd6;
   localparam logic [2:0] DM_SW  = 3'd7;

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic [2:0]    mode_q;
   logic [1:0]    lane_q;

   logic        access, is_byte, is_half, is_word, mis, start;
   logic [3:0]  be_nxt;
   logic [31:0] wdata_nxt;
   logic        q_byte, q_half, q_unsigned;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_fmt;
   logic        timeout;

   assign access  = mem_read | mem_write;
   assign is_byte = (data_mem_mode == DM_LB) || (data_mem_mode == DM_LBU) || (data_mem_mode == DM_SB);
   assign is_half = (data_mem_mode == DM_LH) || (data_mem_mode == DM_LHU) || (data_mem_mode == DM_SH);
   assign is_word = (data_mem_mode == DM_LW) || (data_mem_mode == DM_SW);
   assign mis     = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
   assign start   = (state == IDLE) & access & ~mis;

   assign misaligned = access & mis;
   assign stall      = start | (state == REQ);
   assign dbg_state  = state;

   // Handshake: bus_req is held high with stable addr/be/wdata/we for the whole REQ
   // state; the single-cycle bus_ack strobe completes it and is ignored in any other state.
   assign bus_req = (state == REQ);
   assign timeout = ~bus_ack & (cnt == CNT_MAX);

   always_comb begin
      be_nxt    = 4'b1111;
      wdata_nxt = 32'h0;
      if (mem_write) begin
         if (is_byte) begin
            be_nxt    = 4'b0001 << addr[1:0];
            wdata_nxt = {4{wdata[7:0]}};
         end else if (is_half) begin
            be_nxt    = 4'b0011 << {addr[1], 1'b0};
            wdata_nxt = {2{wdata[15:0]}};
         end else begin
            wdata_nxt = wdata;
         end
      end
   end

   // Load lane selection uses the address captured at request time.
   assign q_byte     = (mode_q == DM_LB) || (mode_q == DM_LBU) || (mode_q == DM_SB);
   assign q_half     = (mode_q == DM_LH) || (mode_q == DM_LHU) || (mode_q == DM_SH);
   assign q_unsigned = (mode_q == DM_LBU) || (mode_q == DM_LHU);
   assign ld_byte    = 8'(bus_rdata >> {lane_q, 3'b000});
   assign ld_half    = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

   always_comb begin
      ld_fmt = bus_rdata;
      if (q_byte)
         ld_fmt = {{24{ld_byte[7] & ~q_unsigned}}, ld_byte};
      else if (q_half)
         ld_fmt = {{16{ld_half[15] & ~q_unsigned}}, ld_half};
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = REQ;
         REQ:     if (bus_ack || timeout) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         mode_q    <= 3'd0;
         lane_q    <= 2'd0;
         bus_we    <= 1'b0;
         bus_addr  <= 32'h0;
         bus_be    <= 4'h0;
         bus_wdata <= 32'h0;
         rdata     <= 32'h0;
         bus_err   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (start) begin
            cnt       <= '0;
            mode_q    <= data_mem_mode;
            lane_q    <= addr[1:0];
            bus_we    <= mem_write;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= be_nxt;
            bus_wdata <= wdata_nxt;
         end
         if (state == REQ) begin
            if (bus_ack) begin
               rdata <= bus_we ? 32'h0 : ld_fmt;
            end else if (timeout) begin
               bus_err <= 1'b1;
               rdata   <= 32'h0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_lsu_bus_if.sv
// Bench for lsu_bus_if: directed and random loads/stores against a small reference
// model, with expected load data queued at issue and compared when the access completes.
module tb_lsu_bus_if;

   localparam int TO = 4;
   localparam logic [2:0] DM_LB  = 3'd0;
   localparam logic [2:0] DM_LH  = 3'd1;
   localparam logic [2:0] DM_LW  = 3'd2;
   localparam logic [2:0] DM_LBU = 3'd3;
   localparam logic [2:0] DM_LHU = 3'd4;
   localparam logic [2:0] DM_SB  = 3'd5;
   localparam logic [2:0] DM_SH  = 3'd6;
   localparam logic [2:0] DM_SW  = 3'd7;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read, mem_write;
   logic [2:0]  data_mem_mode;
   logic [31:0] addr, wdata;
   logic [31:0] rdata;
   logic        stall, misaligned, bus_err, bus_req, bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata, bus_rdata;
   logic        bus_ack;
   logic [1:0]  dbg_state;

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_q[$];

   lsu_bus_if #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
      .data_mem_mode(data_mem_mode), .addr(addr), .wdata(wdata), .rdata(rdata),
      .stall(stall), .misaligned(misaligned), .bus_err(bus_err), .bus_req(bus_req),
      .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata), .bus_ack(bus_ack), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] model_load(input logic [2:0] mode, input logic [31:0] a,
                                              input logic [31:0] d);
      logic [7:0]  b;
      logic [15:0] h;
      case (a[1:0])
         2'd0: b = d[7:0];
         2'd1: b = d[15:8];
         2'd2: b = d[23:16];
         default: b = d[31:24];
      endcase
      h = a[1] ? d[31:16] : d[15:0];
      case (mode)
         DM_LB:   return b[7] ? {24'hFFFFFF, b} : {24'h0, b};
         DM_LBU:  return {24'h0, b};
         DM_LH:   return h[15] ? {16'hFFFF, h} : {16'h0, h};
         DM_LHU:  return {16'h0, h};
         default: return d;
      endcase
   endfunction

   function automatic logic [3:0] model_be(input logic wr, input logic [2:0] mode,
                                           input logic [1:0] a);
      if (!wr || mode == DM_SW) return 4'b1111;
      if (mode == DM_SH) return a[1] ? 4'b1100 : 4'b0011;
      case (a)
         2'd0: return 4'b0001;
         2'd1: return 4'b0010;
         2'd2: return 4'b0100;
         default: return 4'b1000;
      endcase
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] mode, input logic [31:0] d);
      if (mode == DM_SB) return {d[7:0], d[7:0], d[7:0], d[7:0]};
      if (mode == DM_SH) return {d[15:0], d[15:0]};
      return d;
   endfunction

   // ack_at: REQ cycle index (0-based) carrying bus_ack; -1 means never ack.
   task automatic do_access(input string tag, input logic wr, input logic [2:0] mode,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rd_data, input int ack_at, input int exp_stall);
      int n;
      int stalls;
      mem_read      = ~wr;
      mem_write     = wr;
      data_mem_mode = mode;
      addr          = a;
      wdata         = wd;
      bus_rdata     = rd_data;
      bus_ack       = 1'b0;
      exp_q.push_back(wr ? 32'h0 : ((ack_at < 0) ? 32'h0 : model_load(mode, a, rd_data)));
      #1;
      check_val({tag, "_idle_stall"}, 32'(stall), 32'd1);
      check_val({tag, "_idle_mis"}, 32'(misaligned), 32'd0);
      stalls = 1;
      @(posedge clk); #1;
      n = 0;
      while (dbg_state == 2'd1 && n < 40) begin
         if (n == 0) begin
            check_val({tag, "_req"}, 32'(bus_req), 32'd1);
            check_val({tag, "_we"}, 32'(bus_we), 32'(wr));
            check_val({tag, "_addr"}, bus_addr, {a[31:2], 2'b00});
            check_val({tag, "_be"}, 32'(bus_be), 32'(model_be(wr, mode, a[1:0])));
            if (wr) check_val({tag, "_wdata"}, bus_wdata, model_wdata(mode, wd));
         end
         stalls += int'(stall);
         bus_ack = (n == ack_at);
         n++;
         @(posedge clk); #1;
      end
      bus_ack = 1'b0;
      check_val({tag, "_done_state"}, 32'(dbg_state), 32'd2);
      check_val({tag, "_done_stall"}, 32'(stall), 32'd0);
      check_val({tag, "_done_req"}, 32'(bus_req), 32'd0);
      if (exp_q.size() > 0) check_val({tag, "_rdata"}, rdata, exp_q.pop_front());
      check_val({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
      mem_read  = 1'b0;
      mem_write = 1'b0;
      @(posedge clk); #1;
      check_val({tag, "_back_idle"}, 32'(dbg_state), 32'd0);
   endtask

   task automatic do_misaligned(input string tag, input logic [2:0] mode, input logic [31:0] a);
      mem_read      = 1'b1;
      mem_write     = 1'b0;
      data_mem_mode = mode;
      addr          = a;
      #1;
      check_val({tag, "_mis"}, 32'(misaligned), 32'd1);
      check_val({tag, "_stall"}, 32'(stall), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check_val({tag, "_no_req"}, 32'(bus_req), 32'd0);
      end
      mem_read = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; data_mem_mode = 3'd0;
      addr = 32'h0; wdata = 32'h0; bus_rdata = 32'h0; bus_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_state", 32'(dbg_state), 32'd0);
      check_val("rst_req", 32'(bus_req), 32'd0);
      check_val("rst_we", 32'(bus_we), 32'd0);
      check_val("rst_addr", bus_addr, 32'h0);
      check_val("rst_be", 32'(bus_be), 32'd0);
      check_val("rst_wdata", bus_wdata, 32'h0);
      check_val("rst_rdata", rdata, 32'h0);
      check_val("rst_err", 32'(bus_err), 32'd0);
      check_val("rst_stall", 32'(stall), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      do_access("sw",  1'b1, DM_SW,  32'h100, 32'hDEADBEEF, 32'h0, 1, 3);
      do_access("sb",  1'b1, DM_SB,  32'h103, 32'h000000A5, 32'h0, 0, 2);
      do_access("sh",  1'b1, DM_SH,  32'h102, 32'h0000BEEF, 32'h0, 2, 4);
      do_access("lb",  1'b0, DM_LB,  32'h201, 32'h0, 32'h12348056, 0, 2);
      do_access("lbu", 1'b0, DM_LBU, 32'h201, 32'h0, 32'h12348056, 0, 2);
      do_access("lh",  1'b0, DM_LH,  32'h202, 32'h0, 32'h12348056, 1, 3);
      do_access("lh0", 1'b0, DM_LH,  32'h200, 32'h0, 32'h12348056, 0, 2);
      do_access("lhu", 1'b0, DM_LHU, 32'h200, 32'h0, 32'h12348056, 0, 2);
      do_access("lw",  1'b0, DM_LW,  32'h204, 32'h0, 32'hCAFEF00D, 0, 2);

      do_misaligned("mis_lw", DM_LW, 32'h102);
      do_misaligned("mis_lh", DM_LH, 32'h101);

      // Stray ack while idle must not disturb anything.
      bus_ack = 1'b1;
      @(posedge clk); #1;
      bus_ack = 1'b0;
      check_val("stray_ack_state", 32'(dbg_state), 32'd0);
      check_val("stray_ack_rdata", rdata, 32'hCAFEF00D);

      for (int i = 0; i < 8; i++) begin
         logic [2:0]  m;
         logic [31:0] a;
         m = 3'($urandom_range(0, 4));
         a = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
         if (m == DM_LB || m == DM_LBU) a[1:0] = 2'($urandom_range(0, 3));
         if (m == DM_LH || m == DM_LHU) a[1] = 1'($urandom_range(0, 1));
         do_access("rnd_ld", 1'b0, m, a, 32'h0, $urandom, 0, 2);
      end

      check_val("err_before_to", 32'(bus_err), 32'd0);
      do_access("timeout", 1'b0, DM_LW, 32'h300, 32'h0, 32'h5555AAAA, -1, TO + 1);
      check_val("err_after_to", 32'(bus_err), 32'd1);
      do_access("post_to", 1'b0, DM_LW, 32'h304, 32'h0, 32'h01020304, 0, 2);
      check_val("err_sticky", 32'(bus_err), 32'd1);

      // Reset in the middle of a request; the late ack arrives while idle.
      mem_read = 1'b1; data_mem_mode = DM_LW; addr = 32'h400; bus_rdata = 32'h77777777;
      @(posedge clk); #1;
      check_val("rstreq_in_req", 32'(dbg_state), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; mem_read = 1'b0; bus_ack = 1'b1;
      @(posedge clk); #1;
      bus_ack = 1'b0;
      check_val("rstreq_state", 32'(dbg_state), 32'd0);
      check_val("rstreq_req", 32'(bus_req), 32'd0);
      check_val("rstreq_rdata", rdata, 32'h0);
      check_val("rstreq_err", 32'(bus_err), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
